// File: rtl/pvz_pkg.sv
// Shared definitions for the zombie wave scheduler: game states, lane count,
// default quotas and lawn geometry.
package pvz_pkg;

  localparam int unsigned NUM_LANES   = 5;
  localparam int unsigned DEF_Q1      = 5;
  localparam int unsigned DEF_Q2      = 10;
  localparam int unsigned DEF_Q3      = 15;
  localparam int unsigned SPAWN_X     = 799;
  localparam int unsigned END_OF_LAWN = 0;

  // One-hot encoding is visible on the state output, bit 0 = idle.
  typedef enum logic [7:0] {
    ST_I      = 8'h01,
    ST_L1     = 8'h02,
    ST_NL2    = 8'h04,
    ST_L2     = 8'h08,
    ST_NL3    = 8'h10,
    ST_L3     = 8'h20,
    ST_DONE_L = 8'h40,
    ST_DONE_W = 8'h80
  } game_state_t;

  function automatic logic [2:0] lane_count(logic [NUM_LANES-1:0] m);
    logic [2:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      c = c + {2'b00, m[i]};
    end
    return c;
  endfunction

  // Done states keep showing the level the game ended on.
  function automatic logic [1:0] level_of(game_state_t s, logic [1:0] held);
    case (s)
      ST_L1:                return 2'd1;
      ST_NL2, ST_L2:        return 2'd2;
      ST_NL3, ST_L3:        return 2'd3;
      ST_DONE_L, ST_DONE_W: return held;
      default:              return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/zombie_wave_scheduler_if.sv
// Game-control bus between the input/lane datapath (master) and the
// wave scheduler (slave).
interface zombie_wave_scheduler_if;
  import pvz_pkg::*;

  logic                 start;
  logic [NUM_LANES-1:0] kill;
  logic [NUM_LANES-1:0] breach;
  logic [NUM_LANES-1:0] spawn;
  logic [NUM_LANES-1:0] lane_active;
  logic                 move_tick;
  logic [1:0]           level;
  logic [7:0]           state;
  logic [15:0]          zombies_killed;

  modport master (
    output start, kill, breach,
    input  spawn, lane_active, move_tick, level, state, zombies_killed
  );

  modport slave (
    input  start, kill, breach,
    output spawn, lane_active, move_tick, level, state, zombies_killed
  );

endinterface

// File: rtl/zombie_wave_scheduler_lane_rr_picker.sv
// Round-robin free-lane search: first free lane at or after the pointer,
// wrapping modulo the lane count.
module lane_rr_picker
  import pvz_pkg::*;
(
  input  logic [NUM_LANES-1:0] free,
  input  logic [2:0]           pointer,
  output logic                 found,
  output logic [2:0]           index
);

  logic [3:0] cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      cand = {1'b0, pointer} + 4'(k);
      if (cand >= 4'(NUM_LANES)) cand = cand - 4'(NUM_LANES);
      if (!found && free[cand[2:0]]) begin
        found = 1'b1;
        index = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/zombie_wave_scheduler.sv
// Level sequencing, move-tick generation and lane spawn scheduling for the
// zombie game; pixel and colour generation live downstream.
module zombie_wave_scheduler
  import pvz_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned SPAWN_GAP = 40,
  parameter int unsigned Q1        = DEF_Q1,
  parameter int unsigned Q2        = DEF_Q2,
  parameter int unsigned Q3        = DEF_Q3
) (
  input  logic                    clk,
  input  logic                    reset,
  zombie_wave_scheduler_if.slave  bus
);

  localparam int unsigned TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int unsigned GW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(SPAWN_GAP - 1);

  game_state_t          st_q, st_d;
  logic [TW-1:0]        tick_q;
  logic [GW-1:0]        gap_q;
  logic [NUM_LANES-1:0] act_q, spawn_q, kills, spawn_mask;
  logic [2:0]           ptr_q, pick, nkill;
  logic [7:0]           spawned_q, lkill_q, quota;
  logic [15:0]          zk_q, zk_next;
  logic [16:0]          zk_sum;
  logic [1:0]           lvl_q;
  logic                 in_level, chg, move_tick, opp, found, do_spawn, breach_hit;

  assign in_level   = st_q inside {ST_L1, ST_L2, ST_L3};
  assign chg        = (st_d != st_q);
  assign move_tick  = in_level && (tick_q == TICK_LAST);
  assign kills      = bus.kill & act_q;
  assign nkill      = lane_count(kills);
  assign breach_hit = |(bus.breach & act_q);
  assign zk_sum     = {1'b0, zk_q} + {14'b0, nkill};
  assign zk_next    = zk_sum[16] ? '1 : zk_sum[15:0];

  always_comb begin
    quota = '0;
    case (st_q)
      ST_L1:   quota = 8'(Q1);
      ST_L2:   quota = 8'(Q2);
      ST_L3:   quota = 8'(Q3);
      default: quota = '0;
    endcase
  end

  lane_rr_picker u_picker (
    .free    (~act_q),
    .pointer (ptr_q),
    .found   (found),
    .index   (pick)
  );

  // Gap counter starts at zero on level entry, so the first move tick of a
  // level is already a spawn opportunity; later ones are SPAWN_GAP apart.
  assign opp        = move_tick && (gap_q == '0);
  assign do_spawn   = opp && found && (spawned_q < quota) && !chg;
  assign spawn_mask = do_spawn ? (NUM_LANES'(1) << pick) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_q <= ST_I;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_I:                 if (bus.start) st_d = ST_L1;
      ST_NL2:               if (bus.start) st_d = ST_L2;
      ST_NL3:               if (bus.start) st_d = ST_L3;
      ST_DONE_L, ST_DONE_W: if (bus.start) st_d = ST_I;
      ST_L1: begin
        if (breach_hit)           st_d = ST_DONE_L;
        else if (lkill_q == quota) st_d = ST_NL2;
      end
      ST_L2: begin
        if (breach_hit)           st_d = ST_DONE_L;
        else if (lkill_q == quota) st_d = ST_NL3;
      end
      ST_L3: begin
        if (breach_hit)           st_d = ST_DONE_L;
        else if (lkill_q == quota) st_d = ST_DONE_W;
      end
      default: st_d = ST_I;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q    <= '0;
      gap_q     <= '0;
      act_q     <= '0;
      spawn_q   <= '0;
      ptr_q     <= '0;
      spawned_q <= '0;
      lkill_q   <= '0;
      zk_q      <= '0;
      lvl_q     <= '0;
    end else begin
      spawn_q <= '0;

      if (chg) begin
        tick_q <= '0;
        gap_q  <= '0;
        lvl_q  <= level_of(st_d, lvl_q);
      end else if (in_level) begin
        tick_q <= move_tick ? '0 : tick_q + 1'b1;
        if (move_tick) gap_q <= (gap_q == '0) ? GAP_RELOAD : gap_q - 1'b1;
      end

      if (st_q == ST_I && st_d == ST_L1) zk_q <= '0;
      else if (in_level)                 zk_q <= zk_next;

      if (in_level) begin
        if (chg) begin
          act_q     <= '0;
          spawned_q <= '0;
          lkill_q   <= '0;
          ptr_q     <= '0;
        end else begin
          act_q   <= (act_q & ~kills) | spawn_mask;
          lkill_q <= lkill_q + {5'b0, nkill};
          if (do_spawn) begin
            spawn_q   <= spawn_mask;
            ptr_q     <= (pick == 3'(NUM_LANES - 1)) ? '0 : pick + 3'd1;
            spawned_q <= spawned_q + 8'd1;
          end
        end
      end
    end
  end

  assign bus.spawn          = spawn_q;
  assign bus.lane_active    = act_q;
  assign bus.move_tick      = move_tick;
  assign bus.level          = lvl_q;
  assign bus.state          = st_q;
  assign bus.zombies_killed = zk_q;

endmodule
